// File: rtl/wb_irq_bus_arbiter_if.sv
// Bus bundle between the core-side Wishbone masters, the arbiter and the shared
// interrupt-controller register port. Modport master is the arbiter's view, slave the environment's.
interface wb_irq_bus_arbiter_if #(
  parameter int CORE_NUM = 2,
  parameter int AW       = 32,
  parameter int DW       = 32
);
  logic [CORE_NUM-1:0]        m_cyc_i;
  logic [CORE_NUM-1:0]        m_stb_i;
  logic [CORE_NUM-1:0]        m_we_i;
  logic [CORE_NUM*AW-1:0]     m_addr_i;
  logic [CORE_NUM*DW-1:0]     m_wdata_i;
  logic [CORE_NUM*DW/8-1:0]   m_sel_i;
  logic [CORE_NUM-1:0]        m_ack_o;
  logic [CORE_NUM-1:0]        m_err_o;
  logic [CORE_NUM*DW-1:0]     m_rdata_o;
  logic                       s_cyc_o;
  logic                       s_stb_o;
  logic                       s_we_o;
  logic [AW-1:0]              s_addr_o;
  logic [DW-1:0]              s_wdata_o;
  logic [DW/8-1:0]            s_sel_o;
  logic                       s_ack_i;
  logic [DW-1:0]              s_rdata_i;
  logic [CORE_NUM-1:0]        grant_o;

  modport master (
    input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_wdata_i, m_sel_i, s_ack_i, s_rdata_i,
    output m_ack_o, m_err_o, m_rdata_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_wdata_o,
           s_sel_o, grant_o
  );

  modport slave (
    output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_wdata_i, m_sel_i, s_ack_i, s_rdata_i,
    input  m_ack_o, m_err_o, m_rdata_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_wdata_o,
           s_sel_o, grant_o
  );
endinterface

// File: rtl/wb_irq_bus_arbiter.sv
// Round-robin, bus-locking arbiter sharing one Wishbone slave port between CORE_NUM masters.
// Define WB_ARB_TIMEOUT_EN to add the no-ack timeout counter and the ABORT state.
module wb_irq_bus_arbiter #(
  parameter int CORE_NUM       = 2,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                  clk,
  input logic                  rst,
  wb_irq_bus_arbiter_if.master bus
);
  localparam int IW = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1;
  localparam int SW = DW / 8;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ABORT = 2'd2} state_t;
  logic [CW-1:0] to_cnt;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;
`endif

  state_t              state;
  logic [CORE_NUM-1:0] grant;
  logic [IW-1:0]       gnt_idx;
  logic [IW-1:0]       last_grant;
  logic [IW-1:0]       rr_idx;
  logic [IW-1:0]       cand;
  logic                rr_hit;
  logic                cyc_g;
  logic                stb_g;
  logic                busy;

  assign cyc_g = bus.m_cyc_i[gnt_idx];
  assign stb_g = bus.m_stb_i[gnt_idx];
  // Reset gates the datapath immediately so no beat leaks through the reset edge.
  assign busy  = (state == BUSY) && !rst;

  // Round-robin search starting just after the last granted master.
  always_comb begin
    rr_idx = last_grant;
    rr_hit = 1'b0;
    cand   = last_grant;
    for (int i = 1; i <= CORE_NUM; i++) begin
      cand = IW'((int'(last_grant) + i) % CORE_NUM);
      if (!rr_hit && bus.m_cyc_i[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end else begin
        rr_hit = rr_hit;
      end
    end
  end

  assign bus.s_cyc_o   = busy & cyc_g;
  assign bus.s_stb_o   = busy & stb_g;
  assign bus.s_we_o    = busy & bus.m_we_i[gnt_idx];
  assign bus.s_addr_o  = busy ? bus.m_addr_i[gnt_idx*AW +: AW] : {AW{1'b0}};
  assign bus.s_wdata_o = busy ? bus.m_wdata_i[gnt_idx*DW +: DW] : {DW{1'b0}};
  assign bus.s_sel_o   = busy ? bus.m_sel_i[gnt_idx*SW +: SW] : {SW{1'b0}};
  assign bus.grant_o   = grant;

  // Slave response routed to the granted master only; error flagged while aborting.
  always_comb begin
    bus.m_ack_o   = {CORE_NUM{1'b0}};
    bus.m_err_o   = {CORE_NUM{1'b0}};
    bus.m_rdata_o = {(CORE_NUM*DW){1'b0}};
    if (busy) begin
      bus.m_ack_o[gnt_idx]              = bus.s_ack_i;
      bus.m_rdata_o[gnt_idx*DW +: DW]   = bus.s_rdata_i;
    end else begin
`ifdef WB_ARB_TIMEOUT_EN
      if ((state == ABORT) && !rst) begin
        bus.m_err_o[gnt_idx] = 1'b1;
      end else begin
        bus.m_err_o = {CORE_NUM{1'b0}};
      end
`else
      bus.m_err_o = {CORE_NUM{1'b0}};
`endif
    end
  end

  // Arbitration FSM with registered grant; the grant holds until the owner drops cyc.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= {CORE_NUM{1'b0}};
      gnt_idx    <= {IW{1'b0}};
      last_grant <= IW'(CORE_NUM - 1);
`ifdef WB_ARB_TIMEOUT_EN
      to_cnt     <= {CW{1'b0}};
`endif
    end else begin
      case (state)
        IDLE: begin
          if (rr_hit) begin
            state      <= BUSY;
            grant      <= CORE_NUM'(1'b1) << rr_idx;
            gnt_idx    <= rr_idx;
            last_grant <= rr_idx;
          end else begin
            grant      <= {CORE_NUM{1'b0}};
          end
        end
        BUSY: begin
          if (!cyc_g) begin
            state  <= IDLE;
            grant  <= {CORE_NUM{1'b0}};
`ifdef WB_ARB_TIMEOUT_EN
            to_cnt <= {CW{1'b0}};
          end else if (stb_g && !bus.s_ack_i) begin
            if (to_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
              state  <= ABORT;
              to_cnt <= {CW{1'b0}};
            end else begin
              to_cnt <= to_cnt + CW'(1);
            end
          end else begin
            to_cnt <= {CW{1'b0}};
`else
          end else begin
            state <= BUSY;
`endif
          end
        end
`ifdef WB_ARB_TIMEOUT_EN
        ABORT: begin
          if (!cyc_g) begin
            state <= IDLE;
            grant <= {CORE_NUM{1'b0}};
          end else begin
            state <= ABORT;
          end
        end
`endif
        default: begin
          state <= IDLE;
          grant <= {CORE_NUM{1'b0}};
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_irq_bus_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against an ownership model.
module tb_wb_irq_bus_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_irq_bus_arbiter_if #(.CORE_NUM(N), .AW(AW), .DW(DW)) bus ();

  wb_irq_bus_arbiter #(.CORE_NUM(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the bus (-1 = nobody), who owned it last, stall run length.
  int owner;
  int last;
  int stall_run;
  bit aborted;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function void model_reset();
    owner     = -1;
    last      = N - 1;
    stall_run = 0;
    aborted   = 1'b0;
  endfunction

  function void model_clock();
    if (rst) begin
      model_reset();
    end else if (owner < 0) begin
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (last + i) % N;
        if (bus.m_cyc_i[c]) begin
          owner     = c;
          last      = c;
          stall_run = 0;
          break;
        end
      end
    end else if (!bus.m_cyc_i[owner]) begin
      owner     = -1;
      aborted   = 1'b0;
      stall_run = 0;
    end else if (TO_EN && !aborted) begin
      if (bus.m_stb_i[owner] && !bus.s_ack_i) begin
        stall_run++;
        if (stall_run >= TO) begin
          aborted   = 1'b1;
          stall_run = 0;
        end
      end else begin
        stall_run = 0;
      end
    end
  endfunction

  // Compare every output against the model, then advance one clock.
  task automatic step();
    logic [63:0] e_cyc, e_stb, e_we, e_addr, e_wdata, e_sel, e_ack, e_err, e_rdata;
    e_cyc = 0; e_stb = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_sel = 0;
    e_ack = 0; e_err = 0; e_rdata = 0;
    #1;
    if (owner >= 0 && !rst && !aborted) begin
      e_cyc   = 64'(bus.m_cyc_i[owner]);
      e_stb   = 64'(bus.m_stb_i[owner]);
      e_we    = 64'(bus.m_we_i[owner]);
      e_addr  = 64'(bus.m_addr_i[owner*AW +: AW]);
      e_wdata = 64'(bus.m_wdata_i[owner*DW +: DW]);
      e_sel   = 64'(bus.m_sel_i[owner*(DW/8) +: (DW/8)]);
      e_ack   = bus.s_ack_i ? (64'd1 << owner) : 64'd0;
      e_rdata = 64'(bus.s_rdata_i) << (owner * DW);
    end
    if (owner >= 0 && !rst && aborted) e_err = 64'd1 << owner;
    check_eq("grant",   64'(bus.grant_o),   (owner >= 0) ? (64'd1 << owner) : 64'd0);
    check_eq("s_cyc",   64'(bus.s_cyc_o),   e_cyc);
    check_eq("s_stb",   64'(bus.s_stb_o),   e_stb);
    check_eq("s_we",    64'(bus.s_we_o),    e_we);
    check_eq("s_addr",  64'(bus.s_addr_o),  e_addr);
    check_eq("s_wdata", 64'(bus.s_wdata_o), e_wdata);
    check_eq("s_sel",   64'(bus.s_sel_o),   e_sel);
    check_eq("m_ack",   64'(bus.m_ack_o),   e_ack);
    check_eq("m_err",   64'(bus.m_err_o),   e_err);
    check_eq("m_rdata", 64'(bus.m_rdata_o), e_rdata);
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic drive(input logic [N-1:0] cyc, input logic [N-1:0] stb,
                       input logic [N-1:0] we, input logic ack);
    bus.m_cyc_i   = cyc;
    bus.m_stb_i   = stb;
    bus.m_we_i    = we;
    bus.m_addr_i  = {$urandom, $urandom};
    bus.m_wdata_i = {$urandom, $urandom};
    bus.m_sel_i   = 8'($urandom);
    bus.s_ack_i   = ack;
    bus.s_rdata_i = $urandom;
  endtask

  initial begin
    logic [N-1:0] rcyc;
    rst = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 1'b0);
    @(posedge clk);
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_grant", 64'(bus.grant_o), 64'd0);
    check_eq("rst_s_cyc", 64'(bus.s_cyc_o), 64'd0);
    check_eq("rst_m_ack", 64'(bus.m_ack_o), 64'd0);
    step();

    // Simultaneous requests: master 0 first, then master 1 after one dead cycle.
    drive(2'b11, 2'b11, 2'b00, 1'b0); step();
    check_eq("both_req_g0", 64'(bus.grant_o), 64'h1);
    drive(2'b10, 2'b10, 2'b00, 1'b0); step();
    check_eq("dead_cycle", 64'(bus.grant_o), 64'h0);
    drive(2'b10, 2'b10, 2'b00, 1'b0); step();
    check_eq("both_req_g1", 64'(bus.grant_o), 64'h2);

    // Master 1 read of 0x0C returning 0x2.
    drive(2'b10, 2'b10, 2'b00, 1'b1);
    bus.m_addr_i[63:32] = 32'h0000_000C;
    bus.s_rdata_i       = 32'h0000_0002;
    #1;
    check_eq("rd_addr",   64'(bus.s_addr_o),         64'hC);
    check_eq("rd_data1",  64'(bus.m_rdata_o[63:32]), 64'h2);
    check_eq("rd_data0",  64'(bus.m_rdata_o[31:0]),  64'h0);
    check_eq("rd_ack",    64'(bus.m_ack_o),          64'h2);
    step();
    drive(2'b00, 2'b00, 2'b00, 1'b0); step(); step();

    // Bus lock across three beats while master 1 waits.
    drive(2'b11, 2'b01, 2'b01, 1'b0); step();
    for (int b = 0; b < 3; b++) begin
      drive(2'b11, 2'b11, 2'b01, 1'b1);
      #1;
      check_eq("lock_grant", 64'(bus.grant_o), 64'h1);
      check_eq("lock_ack",   64'(bus.m_ack_o), 64'h1);
      step();
    end
    drive(2'b10, 2'b10, 2'b00, 1'b0); step();
    check_eq("lock_release", 64'(bus.grant_o), 64'h0);
    step();
    check_eq("lock_next", 64'(bus.grant_o), 64'h2);
    drive(2'b00, 2'b00, 2'b00, 1'b0); step(); step();

    // Master 0 back-to-back tenures.
    drive(2'b01, 2'b01, 2'b00, 1'b1); step();
    check_eq("b2b_first", 64'(bus.grant_o), 64'h1);
    drive(2'b00, 2'b00, 2'b00, 1'b0); step();
    check_eq("b2b_dead", 64'(bus.grant_o), 64'h0);
    drive(2'b01, 2'b01, 2'b00, 1'b1); step();
    check_eq("b2b_second", 64'(bus.grant_o), 64'h1);

    // Reset mid-tenure with an ack arriving.
    rst = 1'b1;
    drive(2'b01, 2'b01, 2'b00, 1'b1);
    #1;
    check_eq("rst_mid_ack", 64'(bus.m_ack_o), 64'h0);
    step();
    check_eq("rst_mid_cyc",   64'(bus.s_cyc_o), 64'h0);
    check_eq("rst_mid_grant", 64'(bus.grant_o), 64'h0);
    rst = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 1'b0); step(); step();

    // Slave never acks.
    drive(2'b01, 2'b01, 2'b00, 1'b0); step();
    repeat (4) begin
      drive(2'b01, 2'b01, 2'b00, 1'b0); step();
    end
    #1;
    if (TO_EN) begin
      check_eq("to_err",   64'(bus.m_err_o), 64'h1);
      check_eq("to_s_cyc", 64'(bus.s_cyc_o), 64'h0);
    end else begin
      check_eq("noto_grant", 64'(bus.grant_o), 64'h1);
      check_eq("noto_s_cyc", 64'(bus.s_cyc_o), 64'h1);
    end
    drive(2'b00, 2'b00, 2'b00, 1'b0); step();
    check_eq("to_idle", 64'(bus.grant_o), 64'h0);
    step();

    // Randomized traffic.
    rcyc = 2'b00;
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 3) == 0) rcyc[k] = ~rcyc[k];
      end
      drive(rcyc, rcyc & 2'($urandom), 2'($urandom), ($urandom_range(0, 2) == 0));
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_irq_bus_arbiter.md
WB_IRQ_BUS_ARBITER -- requirements
Module: wb_irq_bus_arbiter

Interface
REQ-001 The block SHALL have parameter CORE_NUM, default 2, number of core-side Wishbone masters sharing the interrupt-controller register port.
REQ-002 The block SHALL have parameter AW, default 32, address width.
REQ-003 The block SHALL have parameter DW, default 32, data width.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 16, cycles without ack before abort (used only under REQ-026).
REQ-005 The block SHALL have port clk, input, 1, clock.
REQ-006 The block SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-007 The block SHALL have ports m_cyc_i, m_stb_i, m_we_i, input, CORE_NUM each, per-master Wishbone controls.
REQ-008 The block SHALL have ports m_addr_i (CORE_NUM*AW), m_wdata_i (CORE_NUM*DW) and m_sel_i (CORE_NUM*DW/8), inputs, per-master packed, master k at slice k.
REQ-009 The block SHALL have ports m_ack_o and m_err_o, output, CORE_NUM, per-master ack and error.
REQ-010 The block SHALL have port m_rdata_o, output, CORE_NUM*DW, per-master read data.
REQ-011 The block SHALL have ports s_cyc_o, s_stb_o, s_we_o (1), s_addr_o (AW), s_wdata_o (DW) and s_sel_o (DW/8), outputs, slave-side request.
REQ-012 The block SHALL have ports s_ack_i (1) and s_rdata_i (DW), inputs, slave-side response.
REQ-013 The block SHALL have port grant_o, output, CORE_NUM, one-hot registered grant, all-zero when idle.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY and, under REQ-026, ABORT.
REQ-015 In IDLE, if any m_cyc_i bit is high, the block SHALL register a one-hot grant at the next edge and enter BUSY. Arbitration latency is one cycle.
REQ-016 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod CORE_NUM and wraps; the first requesting master wins.
REQ-017 In BUSY the slave outputs SHALL combinationally mirror the granted master's cyc/stb/we/addr/wdata/sel. In IDLE and ABORT they SHALL all be zero.
REQ-018 s_ack_i and s_rdata_i SHALL be routed only to the granted master. All other m_ack_o and m_rdata_o slices SHALL be zero.
REQ-019 BUSY SHALL exit to IDLE at the edge where the granted m_cyc_i is low. Requests from other masters in that cycle are not granted until the following IDLE cycle, giving one mandatory dead cycle between tenures.
REQ-020 Grant SHALL NOT change while the granted m_cyc_i remains high, including across multiple stb/ack beats (bus lock).
REQ-021 last_grant SHALL update on entry to BUSY.
REQ-022 If the granted master drops cyc in the same cycle as s_ack_i, the ack SHALL still be forwarded that cycle and the block SHALL go to IDLE.
REQ-023 Requests from non-granted masters SHALL be held off with no ack and no err; the block SHALL NOT drop them.

Reset
REQ-024 On rst the block SHALL enter IDLE with grant_o=0, last_grant=CORE_NUM-1 (so master 0 has top priority), all m_ack_o/m_err_o/m_rdata_o and s_* outputs 0, and the timeout counter at 0.
REQ-025 Reset asserted mid-tenure SHALL drop s_cyc_o at the same edge. No ack SHALL be forwarded from that edge onward.

Configuration
REQ-026 With macro WB_ARB_TIMEOUT_EN defined, a counter SHALL run in BUSY while s_stb_o=1 and s_ack_i=0, and clear on ack or on exit.
- When the count reaches TIMEOUT_CYCLES, the block SHALL enter ABORT.
- In ABORT, m_err_o of the granted master SHALL stay high until its m_cyc_i falls, then the block returns to IDLE.
REQ-027 Without WB_ARB_TIMEOUT_EN, the block SHALL have no counter and no ABORT state, m_err_o SHALL be tied to 0, and BUSY SHALL wait indefinitely for ack.

Verification
REQ-028 After reset, m_cyc_i=2'b11 on the same cycle -> grant_o=2'b01 one cycle later; after master 0 releases, one idle cycle, then grant_o=2'b10.
REQ-029 Master 1 reads addr 0x0C, slave acks with rdata 0x2 -> m_rdata_o slice 1 = 0x2 with m_ack_o=2'b10; slice 0 = 0, m_ack_o[0]=0.
REQ-030 Master 0 holds cyc across 3 stb/ack beats while master 1 requests -> grant_o stays 2'b01 for all 3 beats; master 1 is granted 2 cycles after master 0's cyc falls.
REQ-031 Only master 0 requests back-to-back -> each tenure is granted with exactly one dead IDLE cycle between tenures.
REQ-032 Reset pulse asserted while BUSY with an ack pending -> s_cyc_o=0 and grant_o=0 at that edge; the late ack is not forwarded.
REQ-033 With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave never acks -> m_err_o[granted]=1 after 4 stb cycles, s_cyc_o=0, IDLE after master cyc drops. Without the macro, the same stimulus leaves the block in BUSY.
